// File: rtl/math_recon.sv
// -----------------------------------------------------------------------------
// math_recon
// Rebuilds a 4-bit dividend from a (divisor, quotient, remainder) triple as
// a = q*d + r using a 4-step shift-add multiplier, and flags illegal triples.
// Acts as a reconstruction / self-check stage behind the div/mod datapath.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  input triple present
//   in_ready   out  1  block can accept a triple (IDLE only)
//   in_d       in   4  divisor, unsigned
//   in_q       in   4  quotient, unsigned
//   in_r       in   4  remainder, unsigned
//   out_valid  out  1  result present (DONE only)
//   out_ready  in   1  consumer accepts the result
//   out_a      out  8  reconstructed dividend q*d + r
//   out_err    out  1  illegal triple: d == 0 or r >= d
//   out_ovf    out  1  result exceeds 15 (outside the 4-bit dividend range)
// -----------------------------------------------------------------------------
module math_recon (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_d,
    input  logic [3:0] in_q,
    input  logic [3:0] in_r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_a,
    output logic       out_err,
    output logic       out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_q;
    logic [3:0]  r_r;
    logic [7:0]  r_acc;
    logic [7:0]  r_mcand;
    logic [1:0]  r_step;
    logic [7:0]  r_out_a;
    logic        r_out_err;
    logic        r_out_ovf;

    logic        w_illegal;
    logic [7:0]  w_sum;

    // Result does not fit back into the 4-bit dividend range.
    function automatic logic f_exceeds_nibble(input logic [7:0] val);
        return (val > 8'd15);
    endfunction

    assign w_illegal = (in_d == 4'd0) || (in_r >= in_d);
    // Max 15*15 + 14 = 239, so the 8-bit sum never wraps.
    assign w_sum     = r_acc + {4'b0000, r_r};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_a     = r_out_a;
    assign out_err   = r_out_err;
    assign out_ovf   = r_out_ovf;

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next-state decode ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_illegal ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (r_step == 2'd3) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- datapath ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= 4'd0;
            r_r       <= 4'd0;
            r_acc     <= 8'd0;
            r_mcand   <= 8'd0;
            r_step    <= 2'd0;
            r_out_a   <= 8'd0;
            r_out_err <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q     <= in_q;
                        r_r     <= in_r;
                        r_acc   <= 8'd0;
                        r_mcand <= {4'b0000, in_d};
                        r_step  <= 2'd0;
                        // Illegal triples skip the multiplier; the result
                        // registers are loaded here because ADD is bypassed.
                        if (w_illegal) begin
                            r_out_a   <= 8'd0;
                            r_out_err <= 1'b1;
                            r_out_ovf <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    // One quotient bit per cycle, LSB first.
                    if (r_q[r_step]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_step  <= r_step + 2'd1;
                end
                S_ADD: begin
                    r_out_a   <= w_sum;
                    r_out_ovf <= f_exceeds_nibble(w_sum);
                    r_out_err <= 1'b0;
                end
                default: begin
                    // DONE: results hold until the output handshake.
                end
            endcase
        end
    end

endmodule
